layer_0_input_streamer: RTL and testbench
=========================================

LAYER_0_INPUT_STREAMER -- requirements
Module: layer_0_input_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of one channel sample (IEEE-754 single).
REQ-002 SHALL have parameter IMG_SIZE, default 416, meaning image width and height in pixels.
REQ-003 SHALL have parameter ADDR_WIDTH, default 20, meaning memory address width; must be at least ceil(log2(3*IMG_SIZE*IMG_SIZE)).
REQ-004 Clk  input  1  clock; one clock, all logic on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to stream one full frame.
REQ-007 pause  input  1  while high, no new memory read is issued.
REQ-008 mem_rd_en  output  1  memory read strobe.
REQ-009 mem_addr  output  ADDR_WIDTH  memory read address.
REQ-010 mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after the mem_rd_en cycle.
REQ-011 data_out  output  3*DATA_WIDTH  packed pixel {ch2, ch1, ch0}, with ch0 in [DATA_WIDTH-1:0]; feeds featuremap data_in.
REQ-012 valid_out  output  1  one-cycle qualifier for data_out; feeds featuremap valid_in.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  one-cycle pulse, frame complete.

Function
REQ-015 Memory layout SHALL be planar: PLANE = IMG_SIZE*IMG_SIZE; address of (ch, p) = ch*PLANE + p, with p = row*IMG_SIZE + col raster order.
REQ-016 FSM states SHALL be IDLE, READ, DRAIN.
REQ-017 Transition IDLE->READ SHALL occur on start=1; the pixel counter and channel counter SHALL clear to 0.
REQ-018 In READ with pause=0, the block SHALL assert mem_rd_en=1 with mem_addr = ch*PLANE + p, then advance ch 0->1->2->0, incrementing p when ch wraps.
REQ-019 In READ with pause=1, the block SHALL drive mem_rd_en=0, hold ch and p, and still capture any in-flight read.
REQ-020 When mem_rd_en=0, mem_addr SHALL hold its last value.
REQ-021 Read data returning for ch0 and ch1 SHALL be held in lane registers.
REQ-022 On ch2 data return, the block SHALL register data_out <= {mem_rd_data, lane1, lane0} and valid_out <= 1.
REQ-023 valid_out SHALL therefore be high in cycle T+2, where T is the ch2 issue cycle; it SHALL be low otherwise.
REQ-024 data_out SHALL hold its value until the next valid_out.
REQ-025 Peak throughput SHALL be one pixel per 3 cycles with no bubbles between pixels.
REQ-026 After the ch2 read of p = PLANE-1 is issued, the FSM SHALL go to DRAIN; no further reads are issued.
REQ-027 DRAIN SHALL wait for the final valid_out; done SHALL pulse in that same cycle; the FSM SHALL return to IDLE on the next cycle.
REQ-028 busy SHALL be high from the cycle after start is accepted through the final valid_out cycle, inclusive.
REQ-029 start while busy SHALL be ignored, and the frame SHALL continue unaffected.
REQ-030 start in the cycle after done SHALL be accepted.
REQ-031 Exactly PLANE valid_out pulses SHALL occur per frame; exactly 3*PLANE reads SHALL be issued.
REQ-032 Counter widths SHALL hold PLANE-1 and 2 without wrap; there SHALL be no arithmetic on the data path.

Reset
REQ-033 While Rst=0 at a rising edge, all outputs SHALL be 0: mem_rd_en, mem_addr, data_out, valid_out, busy, done.
REQ-034 While Rst=0 at a rising edge, the FSM SHALL go to IDLE and the counters and lanes SHALL clear to 0.
REQ-035 Reset mid-frame SHALL abort the frame: no done, no further valid_out.
REQ-036 A read in flight at reset SHALL be discarded.
REQ-037 The first start after reset release SHALL begin at p=0, ch=0.

Verification (IMG_SIZE=2, PLANE=4, mem[a] = a + 32'h100)
REQ-038 Scenario 1: Rst=0 for 2 cycles -> all outputs 0, FSM in IDLE.
REQ-039 Scenario 2: single start, pause=0.
- mem_addr sequence 0,4,8,1,5,9,2,6,10,3,7,11 on consecutive cycles.
- First valid_out 2 cycles after addr 8, data_out = {32'h108, 32'h104, 32'h100}.
- 4 valid_out pulses, 3 cycles apart.
- done coincident with data_out = {32'h10B, 32'h107, 32'h103}.
REQ-040 Scenario 3: pause=1 for 3 cycles right after addr 4 is issued.
- mem_rd_en=0 for those 3 cycles.
- Next address is 8.
- First valid_out delayed by exactly 3 cycles with unchanged data; all pixels correct.
REQ-041 Scenario 4: start pulsed again mid-frame -> ignored; still exactly 4 valid_out and 1 done.
REQ-042 Scenario 5: Rst=0 asserted during pixel 2 reads.
- Outputs 0 next cycle; no done.
- A new start then yields the full Scenario 2 sequence from addr 0.
REQ-043 Scenario 6: start in the cycle after done -> new frame begins, addr 0 issued on the following cycle.

Source files
------------

// File: rtl/layer_0_input_streamer_if.sv
// rtl/layer_0_input_streamer_if.sv - memory read bus and pixel output stream of the layer 0 input streamer
interface layer_0_input_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20
);
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_rd_data;
    logic [3*DATA_WIDTH-1:0]   data_out;
    logic                      valid_out;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output data_out,
        output valid_out
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/layer_0_input_streamer.sv
// rtl/layer_0_input_streamer.sv - streams a planar 3-channel frame from memory as packed pixels
module layer_0_input_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 416,
    parameter int ADDR_WIDTH = 20
) (
    input  logic Clk,
    input  logic Rst,
    input  logic start,
    input  logic pause,
    output logic busy,
    output logic done,
    layer_0_input_streamer_if.master bus
);
    localparam int PLANE = IMG_SIZE * IMG_SIZE;
    localparam int P_W   = (PLANE > 1) ? $clog2(PLANE) : 1;

    localparam logic [ADDR_WIDTH-1:0] PLANE_A  = ADDR_WIDTH'(PLANE);
    localparam logic [ADDR_WIDTH-1:0] PLANE2_A = ADDR_WIDTH'(2 * PLANE);
    localparam logic [P_W-1:0]        P_LAST   = P_W'(PLANE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ch_q, ch_d;
    logic [P_W-1:0]          p_q, p_d;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   ch_off;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   last_addr_q;
    logic                    rd_pend_q;
    logic [1:0]              rd_ch_q;
    logic [DATA_WIDTH-1:0]   lane0_q, lane1_q;
    logic [3*DATA_WIDTH-1:0] data_q;
    logic                    valid_q;

    // Next-state, read strobe and channel/pixel counter advance
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        p_d     = p_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    ch_d    = 2'd0;
                    p_d     = '0;
                end
            end
            READ: begin
                if (!pause) begin
                    rd_en = 1'b1;
                    if (ch_q == 2'd2) begin
                        ch_d = 2'd0;
                        if (p_q == P_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            p_d = p_q + 1'b1;
                        end
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                // The only pixel that can complete in DRAIN is the last one.
                if (valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Planar address: channel plane offset plus raster pixel index
    always_comb begin
        ch_off = '0;
        case (ch_q)
            2'd1:    ch_off = PLANE_A;
            2'd2:    ch_off = PLANE2_A;
            default: ch_off = '0;
        endcase
        cur_addr = ch_off + ADDR_WIDTH'(p_q);
    end

    // FSM state and counter registers
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            p_q     <= p_d;
        end
    end

    // Read tracking, lane capture and pixel output register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            last_addr_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_ch_q     <= 2'd0;
            lane0_q     <= '0;
            lane1_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            rd_pend_q <= rd_en;
            rd_ch_q   <= ch_q;
            valid_q   <= 1'b0;
            if (rd_en) begin
                last_addr_q <= cur_addr;
            end
            if (rd_pend_q) begin
                case (rd_ch_q)
                    2'd0:    lane0_q <= bus.mem_rd_data;
                    2'd1:    lane1_q <= bus.mem_rd_data;
                    default: begin
                        data_q  <= {bus.mem_rd_data, lane1_q, lane0_q};
                        valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_en ? cur_addr : last_addr_q;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DRAIN) && valid_q;
endmodule

// File: tb/tb_layer_0_input_streamer.sv
// tb/tb_layer_0_input_streamer.sv - directed bench for layer_0_input_streamer at IMG_SIZE=2
module tb_layer_0_input_streamer;
    logic Clk;
    logic Rst;
    logic start;
    logic pause;
    logic busy;
    logic done;

    layer_0_input_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    layer_0_input_streamer #(
        .DATA_WIDTH(32),
        .IMG_SIZE  (2),
        .ADDR_WIDTH(8)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .start(start),
        .pause(pause),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Memory model: mem[a] = a + 0x100, data one cycle after the strobe, junk otherwise
    always @(posedge Clk) begin
        if (bus.mem_rd_en)
            bus.mem_rd_data <= 32'(bus.mem_addr) + 32'h100;
        else
            bus.mem_rd_data <= 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        s;
        logic        en;
        logic [7:0]  addr;
        logic        valid;
        logic [95:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[16];
    int   checks = 0;
    int   errors = 0;
    int   n_reads, n_valid, n_done, pix;

    function automatic logic [95:0] pixel(input int k);
        logic [31:0] c0, c1, c2;
        c0 = 32'h100 + 32'(k);
        c1 = 32'h104 + 32'(k);
        c2 = 32'h108 + 32'(k);
        return {c2, c1, c0};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_tally();
        n_reads = 0;
        n_valid = 0;
        n_done  = 0;
        pix     = 0;
    endtask

    // One clock: drive inputs just after the edge, observe outputs shortly after
    task automatic cyc(input logic s, input logic p, input logic r);
        @(posedge Clk);
        #1;
        start = s;
        pause = p;
        Rst   = r;
        #1;
        if (bus.mem_rd_en === 1'b1) n_reads++;
        if (bus.valid_out === 1'b1) begin
            chk("pixel_data", bus.data_out, pixel(pix));
            pix++;
            n_valid++;
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic run_to_done();
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            cyc(1'b0, 1'b0, 1'b1);
            got = (done === 1'b1);
            n++;
        end
        chk("done_within_budget", {95'd0, got}, 96'd1);
    endtask

    task automatic check_frame_counts(input string tag);
        chk({tag, "_valid_count"}, 96'(n_valid), 96'd4);
        chk({tag, "_done_count"},  96'(n_done),  96'd1);
        chk({tag, "_read_count"},  96'(n_reads), 96'd12);
    endtask

    task automatic run_table(input string tag);
        clear_tally();
        for (int c = 0; c < 16; c++) begin
            cyc(tbl[c].s, 1'b0, 1'b1);
            chk({tag, "_rd_en"},  {95'd0, bus.mem_rd_en}, {95'd0, tbl[c].en});
            chk({tag, "_addr"},   96'(bus.mem_addr),      96'(tbl[c].addr));
            chk({tag, "_valid"},  {95'd0, bus.valid_out}, {95'd0, tbl[c].valid});
            chk({tag, "_data"},   bus.data_out,           tbl[c].data);
            chk({tag, "_busy"},   {95'd0, busy},          {95'd0, tbl[c].busy});
            chk({tag, "_done"},   {95'd0, done},          {95'd0, tbl[c].done});
        end
    endtask

    initial begin
        int al[12];
        int k;
        al = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

        // Single-frame trace: start in cycle 0, reads in cycles 1..12,
        // pixels in cycles 5, 8, 11, 14, done with the last one.
        for (int c = 0; c < 16; c++) begin
            tbl[c].s     = (c == 0);
            tbl[c].en    = (c >= 1 && c <= 12);
            tbl[c].addr  = (c == 0) ? 8'd0 : (c <= 12) ? 8'(al[c-1]) : 8'd11;
            tbl[c].valid = (c == 5 || c == 8 || c == 11 || c == 14);
            k            = (c < 5) ? -1 : ((c - 5) / 3 > 3 ? 3 : (c - 5) / 3);
            tbl[c].data  = (k < 0) ? 96'd0 : pixel(k);
            tbl[c].busy  = (c >= 1 && c <= 14);
            tbl[c].done  = (c == 14);
        end

        Rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;

        // Reset held for two cycles
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_rd_en", {95'd0, bus.mem_rd_en}, 96'd0);
        chk("rst_addr",  96'(bus.mem_addr),      96'd0);
        chk("rst_data",  bus.data_out,           96'd0);
        chk("rst_valid", {95'd0, bus.valid_out}, 96'd0);
        chk("rst_busy",  {95'd0, busy},          96'd0);
        chk("rst_done",  {95'd0, done},          96'd0);

        // Plain frame
        run_table("frame");
        check_frame_counts("frame");

        // Pause for three cycles right after address 4 is issued
        clear_tally();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pause_addr0", 96'(bus.mem_addr), 96'd0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pause_addr4", 96'(bus.mem_addr), 96'd4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk("pause_rd_en_low", {95'd0, bus.mem_rd_en}, 96'd0);
            chk("pause_addr_hold", 96'(bus.mem_addr),      96'd4);
            chk("pause_no_valid",  {95'd0, bus.valid_out}, 96'd0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("pause_resume_en",   {95'd0, bus.mem_rd_en}, 96'd1);
        chk("pause_resume_addr", 96'(bus.mem_addr),      96'd8);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pause_valid_not_early", {95'd0, bus.valid_out}, 96'd0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pause_valid_delayed", {95'd0, bus.valid_out}, 96'd1);
        run_to_done();
        check_frame_counts("pause");

        // Start pulsed mid-frame and during drain is ignored
        clear_tally();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        run_to_done();
        check_frame_counts("restart_ignored");
        cyc(1'b0, 1'b0, 1'b1);
        chk("restart_ignored_idle", {95'd0, busy}, 96'd0);

        // Reset asserted during pixel 2 reads aborts the frame
        clear_tally();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("abort_rd_en", {95'd0, bus.mem_rd_en}, 96'd0);
        chk("abort_addr",  96'(bus.mem_addr),      96'd0);
        chk("abort_data",  bus.data_out,           96'd0);
        chk("abort_valid", {95'd0, bus.valid_out}, 96'd0);
        chk("abort_busy",  {95'd0, busy},          96'd0);
        clear_tally();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("abort_no_valid", 96'(n_valid), 96'd0);
        chk("abort_no_done",  96'(n_done),  96'd0);
        run_table("after_abort");
        check_frame_counts("after_abort");

        // Start in the cycle right after done
        clear_tally();
        cyc(1'b1, 1'b0, 1'b1);
        run_to_done();
        check_frame_counts("b2b_first");
        clear_tally();
        cyc(1'b1, 1'b0, 1'b1);
        chk("b2b_idle_on_start", {95'd0, busy}, 96'd0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b_rd_en", {95'd0, bus.mem_rd_en}, 96'd1);
        chk("b2b_addr0", 96'(bus.mem_addr),      96'd0);
        chk("b2b_busy",  {95'd0, busy},          96'd1);
        run_to_done();
        check_frame_counts("b2b_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
